// File: rtl/resblock_pkg.sv
// Shared helpers for the residual join: fixed-point operand alignment and
// saturating addition used by every output lane.
package resblock_pkg;

  localparam int SKIP_DEPTH_DEF = 16;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_width(SKIP_DEPTH_DEF);

  // Shift a signed value from frac_in to frac_out fractional bits (floor on right shift).
  function automatic longint align_frac(input longint v, input int frac_in, input int frac_out);
    longint r;
    if (frac_in < frac_out) r = v <<< (frac_out - frac_in);
    else                    r = v >>> (frac_in - frac_out);
    return r;
  endfunction

  // 64-bit intermediate is always wide enough for the aligned sum, so no overflow before clamping.
  function automatic longint sat_add_aligned(input longint a, input int a_frac,
                                             input longint b, input int b_frac,
                                             input int out_w, input int out_frac);
    longint s;
    longint max_v;
    longint min_v;
    s     = align_frac(a, a_frac, out_frac) + align_frac(b, b_frac, out_frac);
    max_v = (longint'(1) <<< (out_w - 1)) - 1;
    min_v = -max_v - 1;
    if (s > max_v)      s = max_v;
    else if (s < min_v) s = min_v;
    return s;
  endfunction

endpackage

// File: rtl/resblock_skip_fifo.sv
// Skip-path tile FIFO: occupancy-counter full/empty, combinational head read.
module resblock_skip_fifo
  import resblock_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/resblock_residual_join.sv
// Residual wrapper: forks input tiles to the branch and a skip FIFO, then joins
// each returning branch tile with the oldest skip tile as a saturated sum.
module resblock_residual_join
  import resblock_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = 8,
  parameter int DATA_IN_0_PRECISION_1  = 4,
  parameter int BRANCH_PRECISION_0     = 8,
  parameter int BRANCH_PRECISION_1     = 4,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 4,
  parameter int COMPUTE_DIM0           = 2,
  parameter int COMPUTE_DIM1           = 2,
  parameter int SKIP_DEPTH             = 16,
  localparam int P    = COMPUTE_DIM0 * COMPUTE_DIM1,
  localparam int SC_W = $clog2(SKIP_DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [P*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                data_in_0_valid,
  output logic                                data_in_0_ready,
  output logic [P*DATA_IN_0_PRECISION_0-1:0]  branch_in_0,
  output logic                                branch_in_0_valid,
  input  logic                                branch_in_0_ready,
  input  logic [P*BRANCH_PRECISION_0-1:0]     branch_out_0,
  input  logic                                branch_out_0_valid,
  output logic                                branch_out_0_ready,
  output logic [P*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                data_out_0_valid,
  input  logic                                data_out_0_ready,
  output logic [SC_W-1:0]                     skip_count
);

  localparam int DIN_W  = DATA_IN_0_PRECISION_0;
  localparam int BR_W   = BRANCH_PRECISION_0;
  localparam int DOUT_W = DATA_OUT_0_PRECISION_0;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [P*DIN_W-1:0]    skip_head;
  logic [P*DOUT_W-1:0]   sum_d;
  logic [P*DOUT_W-1:0]   data_out_q;
  logic                  valid_q;

  // Handshake outputs are forced low while reset is held.
  assign branch_in_0        = data_in_0;
  assign branch_in_0_valid  = rst && data_in_0_valid && !fifo_full;
  assign data_in_0_ready    = rst && branch_in_0_ready && !fifo_full;
  assign push               = data_in_0_valid && data_in_0_ready;
  assign branch_out_0_ready = rst && !fifo_empty && (!valid_q || data_out_0_ready);
  assign pop                = branch_out_0_valid && branch_out_0_ready;

  resblock_skip_fifo #(
    .WORD_W (P*DIN_W),
    .DEPTH  (SKIP_DEPTH)
  ) u_skip_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (data_in_0),
    .pop_i   (pop),
    .rdata_o (skip_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (skip_count)
  );

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      logic signed [DIN_W-1:0] skip_el;
      logic signed [BR_W-1:0]  br_el;
      assign skip_el = skip_head[gi*DIN_W +: DIN_W];
      assign br_el   = branch_out_0[gi*BR_W +: BR_W];
      assign sum_d[gi*DOUT_W +: DOUT_W] = DOUT_W'(sat_add_aligned(
          longint'(skip_el), DATA_IN_0_PRECISION_1,
          longint'(br_el),   BRANCH_PRECISION_1,
          DOUT_W,            DATA_OUT_0_PRECISION_1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      data_out_q <= '0;
    end else if (pop) begin
      valid_q    <= 1'b1;
      data_out_q <= sum_d;
    end else if (data_out_0_ready) begin
      valid_q    <= 1'b0;
    end
  end

  assign data_out_0       = data_out_q;
  assign data_out_0_valid = valid_q;

endmodule

// File: tb/tb_resblock_residual_join.sv
// Bench for resblock_residual_join: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the residual join.
module tb_resblock_residual_join;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din = '0;
  logic        din_v = 1'b0;
  logic        din_r;
  logic [31:0] bin;
  logic        bin_v;
  logic        bin_r = 1'b0;
  logic [31:0] bout = '0;
  logic        bout_v = 1'b0;
  logic        bout_r;
  logic [31:0] dout;
  logic        dout_v;
  logic        dout_r = 1'b0;
  logic [4:0]  cnt;

  logic [31:0] d2_din = '0;
  logic        d2_din_v = 1'b0;
  logic        d2_din_r;
  logic [31:0] d2_bin;
  logic        d2_bin_v;
  logic        d2_bin_r = 1'b0;
  logic [31:0] d2_bout = '0;
  logic        d2_bout_v = 1'b0;
  logic        d2_bout_r;
  logic [31:0] d2_dout;
  logic        d2_dout_v;
  logic        d2_dout_r = 1'b0;
  logic [4:0]  d2_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  resblock_residual_join dut (
    .clk(clk), .rst(rst),
    .data_in_0(din), .data_in_0_valid(din_v), .data_in_0_ready(din_r),
    .branch_in_0(bin), .branch_in_0_valid(bin_v), .branch_in_0_ready(bin_r),
    .branch_out_0(bout), .branch_out_0_valid(bout_v), .branch_out_0_ready(bout_r),
    .data_out_0(dout), .data_out_0_valid(dout_v), .data_out_0_ready(dout_r),
    .skip_count(cnt)
  );

  resblock_residual_join #(.BRANCH_PRECISION_1(6)) dut2 (
    .clk(clk), .rst(rst),
    .data_in_0(d2_din), .data_in_0_valid(d2_din_v), .data_in_0_ready(d2_din_r),
    .branch_in_0(d2_bin), .branch_in_0_valid(d2_bin_v), .branch_in_0_ready(d2_bin_r),
    .branch_out_0(d2_bout), .branch_out_0_valid(d2_bout_v), .branch_out_0_ready(d2_bout_r),
    .data_out_0(d2_dout), .data_out_0_valid(d2_dout_v), .data_out_0_ready(d2_dout_r),
    .skip_count(d2_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected tile: each operand read as a real number, floored onto the 4-bit output grid, summed, clamped.
  function automatic logic [31:0] ref_tile(input logic [31:0] s, input int sf,
                                           input logic [31:0] b, input int bf);
    logic [31:0] r;
    logic [7:0]  se;
    logic [7:0]  be;
    int          a, c, t;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      se = s[i*8 +: 8];
      be = b[i*8 +: 8];
      a = $rtoi($floor($itor($signed(se)) / (2.0 ** sf) * 16.0));
      c = $rtoi($floor($itor($signed(be)) / (2.0 ** bf) * 16.0));
      t = a + c;
      if (t > 127)  t = 127;
      if (t < -128) t = -128;
      r[i*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  // Model state: forked tiles awaiting their branch partner, and the expected output register.
  logic [31:0] skip_q[$];
  bit          mv = 1'b0;
  logic [31:0] md = '0;

  always @(posedge clk) begin
    bit m_full;
    bit m_push;
    bit m_fire;
    if (!rst) begin
      skip_q.delete();
      mv = 1'b0;
      md = '0;
    end else begin
      m_full = (skip_q.size() == 16);
      m_push = din_v && bin_r && !m_full;
      m_fire = bout_v && (skip_q.size() > 0) && (!mv || dout_r);
      if (m_fire) begin
        md = ref_tile(skip_q.pop_front(), 4, bout, 4);
        mv = 1'b1;
      end else if (dout_r) begin
        mv = 1'b0;
      end
      if (m_push) skip_q.push_back(din);
    end
  end

  always @(negedge clk) begin
    bit e_full;
    if (chk_en) begin
      e_full = (skip_q.size() == 16);
      check("data_in_0_ready", 32'(din_r), 32'(rst && bin_r && !e_full));
      check("branch_in_0_valid", 32'(bin_v), 32'(rst && din_v && !e_full));
      check("branch_in_0", bin, din);
      check("branch_out_0_ready", 32'(bout_r), 32'(rst && (skip_q.size() > 0) && (!mv || dout_r)));
      check("data_out_0_valid", 32'(dout_v), 32'(mv));
      if (mv) check("data_out_0", dout, md);
      check("skip_count", 32'(cnt), 32'(skip_q.size()));
    end
  end

  // Handshakes as seen just before each edge, used by the random driver to hold unaccepted beats.
  bit acc_in = 1'b0;
  bit acc_b  = 1'b0;
  always @(negedge clk) begin
    acc_in = din_v && din_r;
    acc_b  = bout_v && bout_r;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [7:0] s, input logic [7:0] b, input logic [7:0] e, input string name);
    din = {4{s}}; din_v = 1'b1; bin_r = 1'b1; dout_r = 1'b1;
    tick();
    din_v = 1'b0;
    bout = {4{b}}; bout_v = 1'b1;
    tick();
    bout_v = 1'b0;
    check({name, "_valid"}, 32'(dout_v), 32'd1);
    check(name, dout, {4{e}});
    tick();
  endtask

  initial begin
    int hc;
    int rate;
    logic [31:0] held;

    tick();
    tick();
    chk_en = 1'b1;
    check("reset_data_out", dout, 32'h0);
    check("reset_count", 32'(cnt), 32'd0);
    rst = 1'b1;
    tick();

    pair(8'h18, 8'h08, 8'h20, "sum_basic");
    pair(8'h7F, 8'h10, 8'h7F, "sat_pos");
    pair(8'h80, 8'hF0, 8'h80, "sat_neg");

    // Branch never returns: fill to full.
    bout_v = 1'b0; bin_r = 1'b1; din_v = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = {4{8'(i * 7 + 3)}};
      tick();
    end
    din = 32'hA5A5A5A5;
    check("full_count", 32'(cnt), 32'd16);
    check("full_in_ready", 32'(din_r), 32'd0);
    bout = 32'h01020304; bout_v = 1'b1;
    check("full_join_ready", 32'(bout_r), 32'd1);
    tick();
    bout_v = 1'b0;
    check("after_pop_count", 32'(cnt), 32'd15);
    check("after_pop_in_ready", 32'(din_r), 32'd1);
    tick();
    check("refill_count", 32'(cnt), 32'd16);
    din_v = 1'b0;

    // Drain everything, then present a branch tile with the FIFO empty.
    bout_v = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bout = $urandom;
      tick();
    end
    check("drained_count", 32'(cnt), 32'd0);
    check("empty_join_ready", 32'(bout_r), 32'd0);
    tick();
    check("empty_still_blocked", 32'(bout_r), 32'd0);
    bout_v = 1'b0;

    // Five distinct tiles, branch delayed by three cycles.
    for (int t = 0; t < 8; t++) begin
      din_v  = (t < 5);
      din    = {4{8'(t * 37 + 5)}};
      bout_v = (t >= 3);
      bout   = {4{8'(t * 11 - 40)}};
      tick();
    end
    bout_v = 1'b0; din_v = 1'b0;
    tick();

    // Back-pressure: output held for four cycles, then one tile per cycle.
    din_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = $urandom;
      tick();
    end
    din_v = 1'b0; dout_r = 1'b0; bout_v = 1'b1; bout = 32'h11223344;
    tick();
    held = dout;
    hc = int'(cnt);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_data_stable", dout, held);
      check("bp_count_stable", 32'(cnt), 32'(hc));
    end
    dout_r = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bout = $urandom;
      tick();
      check("bp_release_count", 32'(cnt), 32'(hc - k));
    end
    bout_v = 1'b0;
    tick();

    // Reset mid-stream with seven tiles stored and a pending output.
    din_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = $urandom;
      tick();
    end
    din_v = 1'b0; dout_r = 1'b0; bout_v = 1'b1;
    tick();
    bout_v = 1'b0;
    check("pre_reset_count", 32'(cnt), 32'd7);
    rst = 1'b0;
    tick();
    check("mid_reset_count", 32'(cnt), 32'd0);
    check("mid_reset_valid", 32'(dout_v), 32'd0);
    check("mid_reset_data", dout, 32'h0);
    rst = 1'b1;
    pair(8'h18, 8'h08, 8'h20, "post_reset_sum");

    // Random traffic; held beats only change once accepted.
    for (int c = 0; c < 2000; c++) begin
      rate = (c < 1000) ? 3 : 1;
      if (!din_v || acc_in) begin
        din_v = ($urandom_range(0, 3) != 0);
        din   = $urandom;
      end
      if (!bout_v || acc_b) begin
        bout_v = ($urandom_range(0, 3) < rate);
        bout   = $urandom;
      end
      bin_r  = ($urandom_range(0, 4) != 0);
      dout_r = ($urandom_range(0, 3) != 0);
      tick();
    end
    din_v = 1'b0; bout_v = 1'b0; dout_r = 1'b1;
    tick();

    // Second instance: branch carries 6 fractional bits.
    d2_din = 32'h10101010; d2_din_v = 1'b1; d2_bin_r = 1'b1; d2_dout_r = 1'b1;
    tick();
    d2_din = 32'hF0F0F0F0;
    tick();
    d2_din_v = 1'b0;
    d2_bout = 32'h13131313; d2_bout_v = 1'b1;
    tick();
    check("frac6_valid", 32'(d2_dout_v), 32'd1);
    check("frac6_sum", d2_dout, 32'h14141414);
    check("frac6_model", d2_dout, ref_tile(32'h10101010, 4, 32'h13131313, 6));
    d2_bout = 32'hFFFFFFFF;
    tick();
    d2_bout_v = 1'b0;
    check("frac6_neg_floor", d2_dout, 32'hEFEFEFEF);
    check("frac6_count", 32'(d2_cnt), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resblock_residual_join.md
# resblock_residual_join

Closes the residual path around the resblock main branch (group_norm_2d → fixed_mish → convolution). Forks each incoming activation tile to the main branch and a skip FIFO, then joins each returning branch tile with its oldest stored skip tile. The join output is element-wise sum = branch + skip, saturated and registered. Sits at both ends of the main branch, so a full residual block is this module plus the branch.

## Interface
- DATA_IN_0_PRECISION_0, 8, total width of block input / skip elements (signed)
- DATA_IN_0_PRECISION_1, 4, fractional bits of block input
- BRANCH_PRECISION_0, 8, total width of branch output elements (signed)
- BRANCH_PRECISION_1, 4, fractional bits of branch output
- DATA_OUT_0_PRECISION_0, 8, total width of result elements (signed)
- DATA_OUT_0_PRECISION_1, 4, fractional bits of result
- COMPUTE_DIM0, 2, tile dimension 0
- COMPUTE_DIM1, 2, tile dimension 1; P = COMPUTE_DIM0*COMPUTE_DIM1 elements per tile
- SKIP_DEPTH, 16, skip FIFO depth in tiles, power of two ≥ 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- data_in_0  in  P×DATA_IN_0_PRECISION_0  block input tile
- data_in_0_valid / data_in_0_ready  in / out  1  input handshake
- branch_in_0  out  P×DATA_IN_0_PRECISION_0  tile to main branch (group_norm_2d input)
- branch_in_0_valid / branch_in_0_ready  out / in  1
- branch_out_0  in  P×BRANCH_PRECISION_0  tile from main branch (convolution output)
- branch_out_0_valid / branch_out_0_ready  in / out  1
- data_out_0  out  P×DATA_OUT_0_PRECISION_0  residual sum tile
- data_out_0_valid / data_out_0_ready  out / in  1
- skip_count  out  $clog2(SKIP_DEPTH)+1  current FIFO occupancy in tiles

## Operation
- Fork, combinational, no storage beyond FIFO:
  - branch_in_0 = data_in_0.
  - branch_in_0_valid = data_in_0_valid && !full.
  - data_in_0_ready = branch_in_0_ready && !full.
  - A fork beat (data_in_0_valid && data_in_0_ready) pushes data_in_0 into the skip FIFO in the same cycle.
- Full blocks push even if a pop occurs in the same cycle. Empty blocks pop; no bypass.
- Join fires when branch_out_0_valid && !empty && (!data_out_0_valid || data_out_0_ready).
  - branch_out_0_ready equals the join-fire condition without the branch_out_0_valid term.
  - Fire: pop FIFO head and load the output register with the sum.
- Per-element arithmetic:
  - Align skip and branch operands to DATA_OUT_0_PRECISION_1. Left shift with zero fill when fewer fractional bits; arithmetic right shift (floor) when more.
  - Add in width = max aligned width + 1.
  - Saturate to the signed DATA_OUT_0_PRECISION_0 range.
- Tiles pair strictly in order. The Nth branch tile combines with the Nth forked tile.
- SKIP_DEPTH must cover the branch's in-flight tile count. If it does not, the fork stalls at full; the join keeps draining.
- skip_count: +1 on push, −1 on pop, unchanged on simultaneous push+pop. Range 0..SKIP_DEPTH.

## Timing
- Reset (rst=0 at a clk edge):
  - data_out_0_valid=0, data_out_0=0, skip_count=0, FIFO pointers=0.
  - data_in_0_ready, branch_in_0_valid, branch_out_0_ready all 0.
- Reset mid-operation discards FIFO contents and the output register. Branch tiles in flight are the integrator's responsibility (the branch is reset on the same rst).
- Fork latency 0 cycles (combinational). FIFO write visible to the join the next cycle.
- Join latency 1 cycle: data_out_0_valid rises the cycle after fire.
- Full throughput 1 tile/cycle when the downstream keeps data_out_0_ready=1.
- data_out_0 and data_out_0_valid are held stable while valid && !ready.
- Pointer wrap-around at SKIP_DEPTH: natural binary wrap. full/empty come from the occupancy counter.

## Structure
- Package resblock_pkg:
  - Operand alignment/saturation function sat_add_aligned, parameterised by widths.
  - Localparam for the counter width.
- Sub-module resblock_skip_fifo: synchronous FIFO, P×DATA_IN_0_PRECISION_0 word, SKIP_DEPTH entries, push/pop/full/empty/count. Unregistered read head; rst active-low synchronous.
- Top: fork glue, join control, P parallel sat_add_aligned lanes, output register.

## Test plan
- Default params:
  - push skip tile of all 0x18 (1.5), branch returns all 0x08 (0.5) → data_out_0 all 0x20, valid one cycle after join.
  - skip 0x7F + branch 0x10 → 0x7F (positive saturate).
  - skip 0x80 + branch 0xF0 → 0x80 (negative saturate).
- Branch never returns: 16 fork beats → skip_count=16, data_in_0_ready=0 on beat 17.
  - Then 1 branch tile arrives → pop; the simultaneous push is refused that cycle and accepted the next.
- Branch tile arrives while FIFO is empty → branch_out_0_ready=0 until a fork beat; pairing stays in order. Send 5 distinct tiles with branch delay 3 and check ordering.
- Back-pressure: hold data_out_0_ready=0 for 4 cycles → data_out_0 stable, no join fires, skip_count unchanged. Release → 1 tile/cycle.
- Reset asserted mid-stream with skip_count=7 → next cycle skip_count=0, data_out_0_valid=0. The first post-reset pair produces the correct sum.
- BRANCH_PRECISION_1=6, DATA_OUT_0_PRECISION_1=4:
  - branch 0x13 (0.296875) aligns to 0x04 by floor.
  - Plus skip 0x10 → 0x14.
